// File: rtl/carry_period_monitor_pkg.sv
// Shared definitions for the carry period monitor: FSM encodings and default widths.
package carry_period_monitor_pkg;

    localparam int DEFAULT_PERIOD_W = 8;
    localparam int DEFAULT_WRAP_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_TIMEOUT = 2'd3
    } mon_state_e;

endpackage

// File: rtl/carry_period_monitor_if.sv
// Period hand-off channel: the monitor drives period/period_valid, downstream drives out_ready.
interface carry_period_monitor_if
    import carry_period_monitor_pkg::*;
#(
    parameter int PERIOD_W = DEFAULT_PERIOD_W
);
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                out_ready;

    modport master (
        output period,
        output period_valid,
        input  out_ready
    );

    modport slave (
        input  period,
        input  period_valid,
        output out_ready
    );
endinterface

// File: rtl/carry_period_monitor_sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset_n || clear) begin
            count_reg <= '0;
        end else if (inc && !(&count_reg)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/carry_period_monitor.sv
// Measures carry-to-carry intervals, counts wraps, flags timeouts and hands periods downstream.
// Optional min/max period tracking is compiled in when PERIOD_MINMAX_EN is defined.
module carry_period_monitor
    import carry_period_monitor_pkg::*;
#(
    parameter int PERIOD_W = DEFAULT_PERIOD_W,
    parameter int WRAP_W   = DEFAULT_WRAP_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                clear_stats,
    input  logic                carry_in,
    input  logic [PERIOD_W-1:0] timeout_limit,
    carry_period_monitor_if.master out_if,
    output logic [WRAP_W-1:0]   wraps,
    output logic                timeout,
    output logic                overrun,
    output logic [PERIOD_W-1:0] min_period,
    output logic [PERIOD_W-1:0] max_period
);
    mon_state_e          state_reg, state_next;
    logic                cnt_clear, cnt_inc;
    logic                capture_evt;
    logic                accept;
    logic                wrap_inc;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W:0]   cnt_plus1;
    logic [PERIOD_W-1:0] measured;

    logic [PERIOD_W-1:0] period_reg;
    logic                period_valid_reg;
    logic                overrun_reg;
    logic                timeout_reg;

    // One extra bit so a saturated count never matches any timeout limit.
    assign cnt_plus1 = {1'b0, cnt} + {{PERIOD_W{1'b0}}, 1'b1};
    assign measured  = (&cnt) ? cnt : cnt_plus1[PERIOD_W-1:0];

    sat_counter #(.W(PERIOD_W)) u_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .count   (cnt)
    );

    always_ff @(posedge clock) begin
        if (reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;
        capture_evt = 1'b0;
        if (!enable) begin
            state_next = ST_IDLE;
            cnt_clear  = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cnt_clear  = 1'b1;
                    state_next = ST_ARMED;
                end
                ST_ARMED: begin
                    if (carry_in) begin
                        cnt_clear  = 1'b1;
                        state_next = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (carry_in) begin
                        cnt_clear   = 1'b1;
                        capture_evt = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                        if ((timeout_limit != '0) && (cnt_plus1 == {1'b0, timeout_limit})) begin
                            state_next = ST_TIMEOUT;
                        end
                    end
                end
                ST_TIMEOUT: begin
                    // The interval that timed out is meaningless, so re-reference without capturing.
                    if (carry_in) begin
                        cnt_clear  = 1'b1;
                        state_next = ST_MEASURE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_clear  = 1'b1;
                end
            endcase
        end
    end

    assign accept   = !period_valid_reg || out_if.out_ready;
    assign wrap_inc = enable && (state_reg != ST_IDLE) && carry_in && !clear_stats;

    sat_counter #(.W(WRAP_W)) u_wraps (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear_stats),
        .inc     (wrap_inc),
        .count   (wraps)
    );

    always_ff @(posedge clock) begin
        if (reset_n) begin
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            timeout_reg <= (state_next == ST_TIMEOUT);
            if (capture_evt && accept) begin
                period_reg       <= measured;
                period_valid_reg <= 1'b1;
            end else if (out_if.out_ready) begin
                period_valid_reg <= 1'b0;
            end
            if (clear_stats) begin
                overrun_reg <= 1'b0;
            end else if (capture_evt && !accept) begin
                overrun_reg <= 1'b1;
            end
        end
    end

`ifdef PERIOD_MINMAX_EN
    logic [PERIOD_W-1:0] min_period_reg, max_period_reg;

    always_ff @(posedge clock) begin
        if (reset_n || clear_stats) begin
            min_period_reg <= '1;
            max_period_reg <= '0;
        end else if (capture_evt && accept) begin
            if (measured < min_period_reg) min_period_reg <= measured;
            if (measured > max_period_reg) max_period_reg <= measured;
        end
    end

    assign min_period = min_period_reg;
    assign max_period = max_period_reg;
`else
    assign min_period = '0;
    assign max_period = '0;
`endif

    assign out_if.period       = period_reg;
    assign out_if.period_valid = period_valid_reg;
    assign overrun             = overrun_reg;
    assign timeout             = timeout_reg;
endmodule

// File: tb/tb_carry_period_monitor.sv
// Directed bench for carry_period_monitor; expected values are worked out by hand per step.
module tb_carry_period_monitor;
    import carry_period_monitor_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       clear_stats = 1'b0;
    logic       carry_in = 1'b0;
    logic [7:0] timeout_limit = 8'd0;
    logic [7:0] wraps;
    logic       timeout;
    logic       overrun;
    logic [7:0] min_period;
    logic [7:0] max_period;

    int checks = 0;
    int failures = 0;

    carry_period_monitor_if #(.PERIOD_W(8)) out_if ();

    carry_period_monitor #(.PERIOD_W(8), .WRAP_W(8)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .clear_stats   (clear_stats),
        .carry_in      (carry_in),
        .timeout_limit (timeout_limit),
        .out_if        (out_if),
        .wraps         (wraps),
        .timeout       (timeout),
        .overrun       (overrun),
        .min_period    (min_period),
        .max_period    (max_period)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected min/max output: tracked value when the feature is built in, else constant 0.
    function automatic logic [31:0] mm(input logic [7:0] v);
`ifdef PERIOD_MINMAX_EN
        return {24'd0, v};
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // gap-1 quiet edges followed by one carry edge: closes an interval of length gap.
    task automatic carry_gap(input int gap);
        carry_in = 1'b0;
        repeat (gap - 1) tick();
        carry_in = 1'b1;
        tick();
        carry_in = 1'b0;
        $display("txn carry gap=%0d period=%0d valid=%0d wraps=%0d overrun=%0d",
                 gap, out_if.period, out_if.period_valid, wraps, overrun);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_period"}, 32'(out_if.period), 32'd0);
        check_eq({tag, "_valid"}, 32'(out_if.period_valid), 32'd0);
        check_eq({tag, "_wraps"}, 32'(wraps), 32'd0);
        check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
        check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
        check_eq({tag, "_min"}, 32'(min_period), mm(8'd255));
        check_eq({tag, "_max"}, 32'(max_period), mm(8'd0));
        check_eq({tag, "_state"}, 32'(dut.state_reg), 32'(ST_IDLE));
    endtask

    initial begin
        out_if.out_ready = 1'b0;
        tick();
        check_reset_values("rst0");
        reset_n = 1'b0;

        // Periodic carries, 16 apart, always accepted.
        enable = 1'b1;
        out_if.out_ready = 1'b1;
        tick();
        carry_in = 1'b1;
        tick();
        carry_in = 1'b0;
        check_eq("ref_wraps", 32'(wraps), 32'd1);
        check_eq("ref_nocapture", 32'(out_if.period_valid), 32'd0);
        carry_gap(16);
        check_eq("p16a_period", 32'(out_if.period), 32'd16);
        check_eq("p16a_valid", 32'(out_if.period_valid), 32'd1);
        check_eq("p16a_wraps", 32'(wraps), 32'd2);
        tick();
        check_eq("p16a_drop", 32'(out_if.period_valid), 32'd0);
        carry_gap(15);
        check_eq("p16b_period", 32'(out_if.period), 32'd16);
        check_eq("p16b_wraps", 32'(wraps), 32'd3);
        tick();
        check_eq("p16b_drop", 32'(out_if.period_valid), 32'd0);

        // Disable: back to IDLE, results retained, carries ignored.
        enable = 1'b0;
        tick();
        check_eq("dis_state", 32'(dut.state_reg), 32'(ST_IDLE));
        check_eq("dis_period", 32'(out_if.period), 32'd16);
        carry_in = 1'b1;
        tick();
        carry_in = 1'b0;
        check_eq("idle_wraps", 32'(wraps), 32'd3);

        // Overrun: carries 4 apart with no acceptance.
        out_if.out_ready = 1'b0;
        enable = 1'b1;
        tick();
        carry_in = 1'b1;
        tick();
        carry_in = 1'b0;
        check_eq("ovr_ref_wraps", 32'(wraps), 32'd4);
        carry_gap(4);
        check_eq("ovr_p4_period", 32'(out_if.period), 32'd4);
        check_eq("ovr_p4_valid", 32'(out_if.period_valid), 32'd1);
        check_eq("ovr_p4_overrun", 32'(overrun), 32'd0);
        carry_gap(4);
        check_eq("ovr_set", 32'(overrun), 32'd1);
        check_eq("ovr_period_kept", 32'(out_if.period), 32'd4);
        check_eq("ovr_wraps", 32'(wraps), 32'd6);
        check_eq("ovr_min", 32'(min_period), mm(8'd4));
        check_eq("ovr_max", 32'(max_period), mm(8'd16));
        out_if.out_ready = 1'b1;
        tick();
        check_eq("ovr_accept", 32'(out_if.period_valid), 32'd0);

        // clear_stats on a quiet edge.
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check_eq("clr_wraps", 32'(wraps), 32'd0);
        check_eq("clr_overrun", 32'(overrun), 32'd0);
        check_eq("clr_min", 32'(min_period), mm(8'd255));
        check_eq("clr_max", 32'(max_period), mm(8'd0));

        // Two quiet edges since the last carry, so this carry closes an interval of 3.
        carry_in = 1'b1;
        tick();
        carry_in = 1'b0;
        check_eq("p3_period", 32'(out_if.period), 32'd3);

        // Timeout at limit 10.
        timeout_limit = 8'd10;
        repeat (9) tick();
        check_eq("to_before", 32'(timeout), 32'd0);
        tick();
        check_eq("to_set", 32'(timeout), 32'd1);
        check_eq("to_state", 32'(dut.state_reg), 32'(ST_TIMEOUT));
        repeat (5) tick();
        check_eq("to_hold", 32'(timeout), 32'd1);
        carry_in = 1'b1;
        tick();
        carry_in = 1'b0;
        check_eq("to_exit", 32'(timeout), 32'd0);
        check_eq("to_nocapture", 32'(out_if.period_valid), 32'd0);
        check_eq("to_period_kept", 32'(out_if.period), 32'd3);
        check_eq("to_wraps", 32'(wraps), 32'd2);
        timeout_limit = 8'd20;
        carry_gap(16);
        check_eq("to_p16", 32'(out_if.period), 32'd16);
        check_eq("to_p16_valid", 32'(out_if.period_valid), 32'd1);

        // New capture on the same edge as acceptance: loads, stays valid, no overrun.
        out_if.out_ready = 1'b0;
        carry_in = 1'b0;
        repeat (4) tick();
        carry_in = 1'b1;
        out_if.out_ready = 1'b1;
        tick();
        carry_in = 1'b0;
        check_eq("sim_period", 32'(out_if.period), 32'd5);
        check_eq("sim_valid", 32'(out_if.period_valid), 32'd1);
        check_eq("sim_overrun", 32'(overrun), 32'd0);
        check_eq("sim_min", 32'(min_period), mm(8'd3));
        check_eq("sim_max", 32'(max_period), mm(8'd16));

        // Dropped measurement coinciding with clear_stats: clear wins over overrun and wraps.
        out_if.out_ready = 1'b0;
        repeat (2) tick();
        carry_in = 1'b1;
        clear_stats = 1'b1;
        tick();
        carry_in = 1'b0;
        clear_stats = 1'b0;
        check_eq("clrc_period", 32'(out_if.period), 32'd5);
        check_eq("clrc_valid", 32'(out_if.period_valid), 32'd1);
        check_eq("clrc_overrun", 32'(overrun), 32'd0);
        check_eq("clrc_wraps", 32'(wraps), 32'd0);

        // Limit 0 disables timeout; the count saturates at 255.
        timeout_limit = 8'd0;
        out_if.out_ready = 1'b1;
        repeat (300) tick();
        check_eq("sat_notimeout", 32'(timeout), 32'd0);
        check_eq("sat_valid_drop", 32'(out_if.period_valid), 32'd0);
        carry_in = 1'b1;
        tick();
        carry_in = 1'b0;
        check_eq("sat_period", 32'(out_if.period), 32'd255);
        check_eq("sat_wraps", 32'(wraps), 32'd1);

        // Min/max over periods 16, 5, 30 after a clear.
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        carry_gap(15);
        check_eq("mm_p16", 32'(out_if.period), 32'd16);
        carry_gap(5);
        check_eq("mm_p5", 32'(out_if.period), 32'd5);
        carry_gap(30);
        check_eq("mm_p30", 32'(out_if.period), 32'd30);
        check_eq("mm_wraps", 32'(wraps), 32'd3);
        check_eq("mm_min", 32'(min_period), mm(8'd5));
        check_eq("mm_max", 32'(max_period), mm(8'd30));
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check_eq("mm_clr_min", 32'(min_period), mm(8'd255));
        check_eq("mm_clr_max", 32'(max_period), mm(8'd0));
        check_eq("mm_clr_wraps", 32'(wraps), 32'd0);

        // Reset mid-measurement with a pending period and cnt=5.
        out_if.out_ready = 1'b0;
        carry_gap(4);
        check_eq("pre_rst_valid", 32'(out_if.period_valid), 32'd1);
        repeat (5) tick();
        check_eq("pre_rst_cnt", 32'(dut.cnt), 32'd5);
        reset_n = 1'b1;
        carry_in = 1'b1;
        tick();
        carry_in = 1'b0;
        check_reset_values("rst1");
        check_eq("rst1_cnt", 32'(dut.cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/carry_period_monitor.md
Name: carry_period_monitor

Overview:
Downstream consumer of the 4-bit loadable counter's carry-out.
- Measures the number of clock cycles between successive carry pulses and counts total wraps.
- Flags a timeout when no carry arrives within a programmable limit.
- Hands each measured period to the next stage over a valid/ready handshake.

Parameters:
PERIOD_W, 8, width of the period measurement, timeout limit and min/max outputs
WRAP_W, 8, width of the wrap (carry event) counter

Ports:
clock  input  1  system clock; all logic on posedge
reset_n  input  1  reset, synchronous, active-high (asserted = 1), despite the _n suffix
enable  input  1  monitor enable; low forces IDLE
clear_stats  input  1  sync pulse; clears wraps, overrun, min/max
carry_in  input  1  carry-out of upstream counter; one cycle high per wrap
timeout_limit  input  PERIOD_W  cycles without carry before timeout; 0 disables timeout
out_ready  input  1  downstream accepts period this cycle
period  output  PERIOD_W  last captured carry-to-carry interval in cycles
period_valid  output  1  period holds unaccepted data
wraps  output  WRAP_W  carry pulses seen while enabled, saturating
timeout  output  1  high while in TIMEOUT state
overrun  output  1  sticky; a measurement was dropped because period_valid was still pending
min_period  output  PERIOD_W  smallest period captured (optional feature)
max_period  output  PERIOD_W  largest period captured (optional feature)

Behaviour:
- Reset (reset_n=1 at edge): state=IDLE, internal cnt=0, period=0, period_valid=0, wraps=0, timeout=0, overrun=0, min_period=all-ones, max_period=0. Reset overrides every other input.
- FSM states: IDLE, ARMED, MEASURE, TIMEOUT. Registered outputs only.
  - IDLE: cnt=0. enable=1 -> ARMED next cycle.
  - ARMED (waiting for first reference carry): carry_in=1 -> MEASURE, cnt<=0. No period captured.
  - MEASURE, carry_in=0: cnt<=cnt+1, saturating at 2^PERIOD_W-1. If timeout_limit!=0 and cnt+1==timeout_limit -> TIMEOUT, timeout<=1.
  - MEASURE, carry_in=1: measured value m = cnt+1, saturated. cnt<=0; stay in MEASURE.
    - Capture m if period_valid==0 or out_ready==1: period<=m, period_valid<=1.
    - Otherwise drop m, keep old period, set overrun<=1.
  - TIMEOUT: cnt frozen, timeout=1. carry_in=1 -> MEASURE, timeout<=0, cnt<=0, no capture (interval invalid).
  - enable=0 in any non-IDLE state -> IDLE next cycle, cnt<=0, timeout<=0. period, period_valid, wraps and overrun are retained.
- Consecutive carries on back-to-back cycles give m=1.
- Handshake:
  - period_valid falls the cycle after an edge where out_ready=1, unless a new capture occurs at that same edge. In that case the new value loads, valid stays 1, and no overrun is flagged.
  - period is stable while period_valid=1 and out_ready=0.
- wraps:
  - +1 on every carry_in=1 edge while state!=IDLE, including the first carry in ARMED; saturates at 2^WRAP_W-1.
  - carry_in is ignored in IDLE.
- clear_stats: wraps<=0, overrun<=0, min/max reset to their reset values.
  - A simultaneous carry still captures or drops the period per the normal rules.
  - A simultaneous carry does not increment wraps; clear wins.
  - A simultaneous overrun is not set; clear wins.
- Latency: period visible one cycle after the closing carry edge.

Optional Feature:
PERIOD_MINMAX_EN:
- Defined: on every capture, min_period<=min(min_period,m) and max_period<=max(max_period,m). Dropped (overrun) measurements are not tracked.
- Undefined: min_period and max_period are driven constant 0 and no comparison logic exists. Ports remain present.

Decomposition:
- Shared package/include: FSM state encodings (IDLE=2'd0, ARMED=2'd1, MEASURE=2'd2, TIMEOUT=2'd3), default PERIOD_W/WRAP_W constants.
- One sub-module: sat_counter (parameterised width, clear, inc, saturating at all-ones). Instantiated for cnt and for wraps.

Test Plan:
- Reset mid-MEASURE with cnt=5 and period_valid=1 -> next cycle all outputs at reset values, state IDLE.
- enable=1, carries every 16 cycles, out_ready=1 -> first carry gives no capture; each later carry gives period=16, period_valid for 1 cycle; wraps increments 1,2,3.
- Carries 4 cycles apart, out_ready=0 -> first capture period=4, valid held; second carry sets overrun=1 with period still 4; out_ready=1 then clears valid.
- timeout_limit=10, no carry after a reference carry -> timeout=1 at cycle 10; next carry clears timeout with no capture; the following carry 16 cycles later captures 16.
- timeout_limit=0, no carries for 300 cycles, PERIOD_W=8 -> no timeout, cnt saturates; next carry captures period=255.
- PERIOD_MINMAX_EN defined, periods 16, 5, 30 -> min_period=5, max_period=30; clear_stats -> min_period=255, max_period=0, wraps=0.
